// File: rtl/shared_data_mem_mp.sv
// rtl/shared_data_mem_mp.sv - N-port AXI4-Lite shared data memory, round-robin arbitrated onto one RAM
// Optional: define SHARED_MEM_OOR_ERR_EN to flag out-of-range addresses with SLVERR instead of wrapping.
module shared_data_mem_mp #(
  parameter int N_PORTS = 2,
  parameter int DW      = 32,
  parameter int DEPTH   = 256,
  parameter int AW      = 32,
  localparam int GW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS*AW-1:0]     s_axi_awaddr,
  input  logic [N_PORTS*3-1:0]      s_axi_awprot,
  input  logic [N_PORTS-1:0]        s_axi_awvalid,
  output logic [N_PORTS-1:0]        s_axi_awready,
  input  logic [N_PORTS*DW-1:0]     s_axi_wdata,
  input  logic [N_PORTS*DW/8-1:0]   s_axi_wstrb,
  input  logic [N_PORTS-1:0]        s_axi_wvalid,
  output logic [N_PORTS-1:0]        s_axi_wready,
  output logic [N_PORTS*2-1:0]      s_axi_bresp,
  output logic [N_PORTS-1:0]        s_axi_bvalid,
  input  logic [N_PORTS-1:0]        s_axi_bready,
  input  logic [N_PORTS*AW-1:0]     s_axi_araddr,
  input  logic [N_PORTS*3-1:0]      s_axi_arprot,
  input  logic [N_PORTS-1:0]        s_axi_arvalid,
  output logic [N_PORTS-1:0]        s_axi_arready,
  output logic [N_PORTS*DW-1:0]     s_axi_rdata,
  output logic [N_PORTS*2-1:0]      s_axi_rresp,
  output logic [N_PORTS-1:0]        s_axi_rvalid,
  input  logic [N_PORTS-1:0]        s_axi_rready,
  output logic                      busy,
  output logic [GW-1:0]             grant
);

  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, WACK, BRESP, RACK, RDATA} state_t;

  state_t             state;
  logic [GW-1:0]      ptr;
  logic [GW-1:0]      sel;
  logic [GW-1:0]      ptr_nxt;
  logic [GW:0]        scan;
  logic [GW:0]        inc;
  logic               found;
  logic               sel_wr;
  logic [N_PORTS-1:0] wr_req;
  logic [N_PORTS-1:0] rd_req;
  logic [AW-1:0]      cur_addr;
  logic [IW-1:0]      idx;
  logic [DW-1:0]      g_wdata;
  logic [SW-1:0]      g_wstrb;
  logic               oor;
  logic [DW-1:0]      rdata_q;
  logic [1:0]         bresp_q;
  logic [1:0]         rresp_q;
  logic               unused_ok;

  logic [DW-1:0] mem [DEPTH];

  // A write needs both AW and W present; a lone half waits.
  assign wr_req = s_axi_awvalid & s_axi_wvalid;
  assign rd_req = s_axi_arvalid;

  always_comb begin
    found  = 1'b0;
    sel    = ptr;
    sel_wr = 1'b0;
    scan   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      scan = {1'b0, ptr} + (GW+1)'(i);
      if (scan >= (GW+1)'(N_PORTS))
        scan = scan - (GW+1)'(N_PORTS);
      if (!found && (wr_req[scan[GW-1:0]] || rd_req[scan[GW-1:0]])) begin
        found  = 1'b1;
        sel    = scan[GW-1:0];
        sel_wr = wr_req[scan[GW-1:0]];
      end
    end
  end

  always_comb begin
    inc     = {1'b0, grant} + (GW+1)'(1);
    ptr_nxt = inc[GW-1:0];
    if (inc >= (GW+1)'(N_PORTS))
      ptr_nxt = '0;
  end

  assign cur_addr = (state == WACK) ? s_axi_awaddr[int'(grant)*AW +: AW]
                                    : s_axi_araddr[int'(grant)*AW +: AW];
  assign idx      = cur_addr[LSB +: IW];
  assign g_wdata  = s_axi_wdata[int'(grant)*DW +: DW];
  assign g_wstrb  = s_axi_wstrb[int'(grant)*SW +: SW];

`ifdef SHARED_MEM_OOR_ERR_EN
  assign oor = |cur_addr[AW-1:LSB+IW];
`else
  assign oor = 1'b0;
`endif

  assign unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot, cur_addr};

  assign s_axi_bresp = {N_PORTS{bresp_q}};
  assign s_axi_rresp = {N_PORTS{rresp_q}};
  assign s_axi_rdata = {N_PORTS{rdata_q}};

  // RAM contents survive reset; a write caught by reset in WACK is dropped.
  always_ff @(posedge clk) begin
    if (!rst && state == WACK && !oor) begin
      for (int b = 0; b < SW; b++)
        if (g_wstrb[b])
          mem[idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      s_axi_awready <= '0;
      s_axi_wready  <= '0;
      s_axi_arready <= '0;
      s_axi_bvalid  <= '0;
      s_axi_rvalid  <= '0;
      bresp_q       <= 2'b00;
      rresp_q       <= 2'b00;
      rdata_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= sel;
            busy  <= 1'b1;
            if (sel_wr) begin
              s_axi_awready[sel] <= 1'b1;
              s_axi_wready[sel]  <= 1'b1;
              state              <= WACK;
            end else begin
              s_axi_arready[sel] <= 1'b1;
              state              <= RACK;
            end
          end
        end
        WACK: begin
          s_axi_awready       <= '0;
          s_axi_wready        <= '0;
          s_axi_bvalid[grant] <= 1'b1;
          bresp_q             <= oor ? 2'b10 : 2'b00;
          state               <= BRESP;
        end
        BRESP: begin
          if (s_axi_bready[grant]) begin
            s_axi_bvalid <= '0;
            busy         <= 1'b0;
            ptr          <= ptr_nxt;
            state        <= IDLE;
          end
        end
        RACK: begin
          s_axi_arready       <= '0;
          s_axi_rvalid[grant] <= 1'b1;
          rdata_q             <= oor ? '0 : mem[idx];
          rresp_q             <= oor ? 2'b10 : 2'b00;
          state               <= RDATA;
        end
        RDATA: begin
          if (s_axi_rready[grant]) begin
            s_axi_rvalid <= '0;
            busy         <= 1'b0;
            ptr          <= ptr_nxt;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_data_mem_mp.sv
// tb/tb_shared_data_mem_mp.sv - scoreboard bench for shared_data_mem_mp (2 ports, 32-bit, 256 words)
module tb_shared_data_mem_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [5:0]  awprot, arprot;
  logic [7:0]  wstrb;
  logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  arvalid, arready, rvalid, rready;
  logic [3:0]  bresp, rresp;
  logic        busy;
  logic [0:0]  grant;

  always #5 clk = ~clk;

  shared_data_mem_mp #(.N_PORTS(2), .DW(32), .DEPTH(256), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .busy(busy), .grant(grant)
  );

  int          total = 0;
  int          bad = 0;
  int          exp_ptr = 0;
  logic [33:0] exp_q[$];
  int          gnt_q[$];
  logic [31:0] mdl[256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit oor_of(input logic [31:0] a);
`ifdef SHARED_MEM_OOR_ERR_EN
    return |a[31:10];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat);
    logic [33:0] e;
    bit done, hs;
    done = 0; hs = 0;
    exp_q.push_back({oor_of(a) ? 2'b10 : 2'b00, 32'h0});
    if (!oor_of(a)) mdl[a[9:2]] = merge(mdl[a[9:2]], d, s);
    awaddr[p*32 +: 32] = a; wdata[p*32 +: 32] = d; wstrb[p*4 +: 4] = s;
    awvalid[p] = 1'b1; wvalid[p] = 1'b1;
    lat = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); lat++;
      if (hs) begin awvalid[p] = 1'b0; wvalid[p] = 1'b0; end
      if (awready[p] && wready[p]) hs = 1;
      if (bvalid[p]) begin
        done = 1;
        e = exp_q.pop_front();
        chk("bresp", {62'b0, bresp[p*2 +: 2]}, {62'b0, e[33:32]});
      end
    end
    if (!done) begin
      chk("wr_timeout", 0, 1);
      awvalid[p] = 1'b0; wvalid[p] = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    exp_ptr = (p + 1) % 2;
  endtask

  task automatic do_read(input int p, input logic [31:0] a, output int lat);
    logic [33:0] e;
    bit done, hs;
    done = 0; hs = 0;
    if (oor_of(a)) exp_q.push_back({2'b10, 32'h0});
    else           exp_q.push_back({2'b00, mdl[a[9:2]]});
    araddr[p*32 +: 32] = a; arvalid[p] = 1'b1;
    lat = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); lat++;
      if (hs) arvalid[p] = 1'b0;
      if (arready[p]) hs = 1;
      if (rvalid[p]) begin
        done = 1;
        e = exp_q.pop_front();
        chk("rdata", {32'b0, rdata[p*32 +: 32]}, {32'b0, e[31:0]});
        chk("rresp", {62'b0, rresp[p*2 +: 2]}, {62'b0, e[33:32]});
      end
    end
    if (!done) begin
      chk("rd_timeout", 0, 1);
      arvalid[p] = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    exp_ptr = (p + 1) % 2;
  endtask

  // Both ports raise a full-strobe write together; grant order must follow the pointer.
  task automatic two_writes(input logic [31:0] a0, input logic [31:0] d0,
                            input logic [31:0] a1, input logic [31:0] d1);
    int first;
    bit [1:0] hs, done;
    hs = 0; done = 0;
    first = exp_ptr;
    gnt_q.push_back(first);
    gnt_q.push_back(1 - first);
    mdl[a0[9:2]] = d0; mdl[a1[9:2]] = d1;
    awaddr = {a1, a0}; wdata = {d1, d0}; wstrb = 8'hFF;
    awvalid = 2'b11; wvalid = 2'b11;
    for (int c = 0; c < 60 && done != 2'b11; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (hs[p]) begin awvalid[p] = 1'b0; wvalid[p] = 1'b0; end
        if (awready[p] && !hs[p]) begin
          hs[p] = 1'b1;
          chk("rr_order", p, (gnt_q.size() > 0) ? gnt_q.pop_front() : -1);
        end
        if (bvalid[p]) done[p] = 1'b1;
      end
    end
    chk("rr_done", {62'b0, done}, 64'd3);
    awvalid = 2'b00; wvalid = 2'b00;
    gnt_q.delete();
    exp_ptr = first;
  endtask

  initial begin
    int lat, hold_err;
    bit ok, hs;
    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    awvalid = '0; wvalid = '0; arvalid = '0; bready = 2'b11; rready = 2'b11;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_awready", {62'b0, awready}, 0);
    chk("rst_wready", {62'b0, wready}, 0);
    chk("rst_arready", {62'b0, arready}, 0);
    chk("rst_bvalid", {62'b0, bvalid}, 0);
    chk("rst_rvalid", {62'b0, rvalid}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {bresp, rresp}, 0);

    do_write(0, 32'h8, 32'hDEADBEEF, 4'hF, lat);
    chk("wr_lat", lat, 2);
    do_read(1, 32'h8, lat);
    chk("rd_lat_b2b", lat, 3);

    two_writes(32'h10, 32'h01010101, 32'h14, 32'h02020202);
    do_write(0, 32'h18, 32'h03030303, 4'hF, lat);
    two_writes(32'h1C, 32'h04040404, 32'h20, 32'h05050505);
    do_read(0, 32'h10, lat);
    do_read(1, 32'h14, lat);
    do_read(0, 32'h1C, lat);
    do_read(1, 32'h20, lat);

    do_write(0, 32'h0, 32'h11223344, 4'hF, lat);
    do_write(1, 32'h0, 32'hAABBCCDD, 4'h5, lat);
    do_read(0, 32'h0, lat);
    do_write(1, 32'h8, 32'hFFFFFFFF, 4'h0, lat);
    do_read(0, 32'h8, lat);

    // Stalled B channel blocks the other port's read until the handshake.
    mdl[3] = 32'h55AA55AA;
    awaddr[31:0] = 32'hC; wdata[31:0] = 32'h55AA55AA; wstrb[3:0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b0;
    ok = 0; hs = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (hs) begin awvalid[0] = 1'b0; wvalid[0] = 1'b0; end
      if (awready[0]) hs = 1;
      if (bvalid[0]) ok = 1;
    end
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    chk("t4_bvalid", ok, 1);
    araddr[63:32] = 32'h8; arvalid[1] = 1'b1;
    hold_err = 0;
    repeat (5) begin
      @(negedge clk);
      if (!bvalid[0] || arready[1] || bresp[1:0] != 2'b00) hold_err++;
    end
    chk("t4_hold", hold_err, 0);
    bready[0] = 1'b1;
    @(negedge clk);
    chk("t4_busy_idle", busy, 0);
    chk("t4_arready_wait", arready[1], 0);
    @(negedge clk);
    chk("t4_grant", grant, 1);
    chk("t4_arready", arready[1], 1);
    @(negedge clk);
    arvalid[1] = 1'b0;
    chk("t4_rvalid", rvalid[1], 1);
    chk("t4_rdata", {32'b0, rdata[63:32]}, {32'b0, mdl[2]});
    @(negedge clk);
    exp_ptr = 0;

    do_read(1, 32'h400, lat);
    do_write(0, 32'h4, 32'h0BADF00D, 4'hF, lat);
    do_write(0, 32'h404, 32'h77777777, 4'hF, lat);
    do_read(0, 32'h4, lat);

    // Reset while RDATA is stalled on port 1.
    araddr[63:32] = 32'h8; arvalid[1] = 1'b1; rready[1] = 1'b0;
    ok = 0; hs = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (hs) arvalid[1] = 1'b0;
      if (arready[1]) hs = 1;
      if (rvalid[1]) ok = 1;
    end
    arvalid[1] = 1'b0;
    chk("t6_rvalid_pre", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rvalid", {62'b0, rvalid}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_grant", grant, 0);
    rst = 1'b0; rready = 2'b11;
    exp_ptr = 0;
    do_read(0, 32'h8, lat);
    chk("rd_lat_idle", lat, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
